// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-pc select: redirect target, sequential step, or hold
module pc_next_logic
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next
);

    // Wraps naturally at 2^32.
    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        pc_next = pc;
        if (redirect_en) begin
            pc_next = redirect_pc & PC_ALIGN_MASK;
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - single-outstanding instruction fetch FSM with redirect and kill
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         kill;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         redirect_en;
    logic         advance;

    assign redirect_en = redirect_valid && (state != ST_IDLE);
    assign advance     = (state == ST_HOLD) && if_ready;

    pc_next_logic u_pc_next (
        .pc          (pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .advance     (advance),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_pc_plus4    <= 32'h0;
            if_instr       <= 32'h0;
        end else begin
            pc <= pc_next;
            unique case (state)
                ST_IDLE: begin
                    state          <= ST_REQ;
                    imem_req_valid <= 1'b1;
                    imem_req_addr  <= pc;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        // A redirect racing the accept makes the in-flight response stale.
                        state          <= ST_WAIT;
                        imem_req_valid <= 1'b0;
                        kill           <= redirect_valid;
                    end else begin
                        imem_req_addr <= pc_next;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redirect_valid) begin
                            kill           <= 1'b0;
                            state          <= ST_REQ;
                            imem_req_valid <= 1'b1;
                            imem_req_addr  <= pc_next;
                        end else begin
                            state       <= ST_HOLD;
                            if_valid    <= 1'b1;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                            if_instr    <= imem_rsp_data;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid || if_ready) begin
                        state          <= ST_REQ;
                        if_valid       <= 1'b0;
                        imem_req_valid <= 1'b1;
                        imem_req_addr  <= pc_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed-vector bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        if_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    logic        u1_redirect_valid;
    logic [31:0] u1_redirect_pc;
    logic        u1_req_ready;
    logic        u1_rsp_valid;
    logic [31:0] u1_rsp_data;
    logic        u1_if_ready;
    logic        u1_req_valid;
    logic [31:0] u1_req_addr;
    logic        u1_if_valid;
    logic [31:0] u1_if_pc;
    logic [31:0] u1_if_pc_plus4;
    logic [31:0] u1_if_instr;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (req_valid),
        .imem_req_addr  (req_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (u1_redirect_valid),
        .redirect_pc    (u1_redirect_pc),
        .imem_req_valid (u1_req_valid),
        .imem_req_addr  (u1_req_addr),
        .imem_req_ready (u1_req_ready),
        .imem_rsp_valid (u1_rsp_valid),
        .imem_rsp_data  (u1_rsp_data),
        .if_valid       (u1_if_valid),
        .if_pc          (u1_if_pc),
        .if_pc_plus4    (u1_if_pc_plus4),
        .if_instr       (u1_if_instr),
        .if_ready       (u1_if_ready)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expects the DUT in REQ at address a; runs accept, response, decode accept.
    task automatic fetch_one(input string tag, input logic [31:0] a, input logic [31:0] d);
        check_vec({tag, ".req_valid"}, {31'h0, req_valid}, 32'h1);
        check_vec({tag, ".req_addr"}, req_addr, a);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check_vec({tag, ".wait_req_valid"}, {31'h0, req_valid}, 32'h0);
        rsp_valid = 1'b1;
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
        check_vec({tag, ".if_valid"}, {31'h0, if_valid}, 32'h1);
        check_vec({tag, ".if_pc"}, if_pc, a);
        check_vec({tag, ".if_pc_plus4"}, if_pc_plus4, a + 32'd4);
        check_vec({tag, ".if_instr"}, if_instr, d);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        check_vec({tag, ".if_valid_drop"}, {31'h0, if_valid}, 32'h0);
    endtask

    initial begin
        rst_n             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        rsp_data          = 32'h0;
        if_ready          = 1'b0;
        u1_redirect_valid = 1'b0;
        u1_redirect_pc    = 32'h0;
        u1_req_ready      = 1'b0;
        u1_rsp_valid      = 1'b0;
        u1_rsp_data       = 32'h0;
        u1_if_ready       = 1'b0;

        repeat (3) tick();
        check_vec("rst.req_valid", {31'h0, req_valid}, 32'h0);
        check_vec("rst.req_addr", req_addr, 32'h0);
        check_vec("rst.if_valid", {31'h0, if_valid}, 32'h0);
        check_vec("rst.if_pc", if_pc, 32'h0);
        check_vec("rst.if_pc_plus4", if_pc_plus4, 32'h0);
        check_vec("rst.if_instr", if_instr, 32'h0);
        check_vec("rst.wrap_req_addr", u1_req_addr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        tick();
        fetch_one("seq0", 32'h0000_0000, 32'h1300_0000);

        // Decode stalls five cycles with the 0x4 instruction held.
        check_vec("bp.req_addr", req_addr, 32'h0000_0004);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h1300_0004;
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_vec("bp.if_valid", {31'h0, if_valid}, 32'h1);
            check_vec("bp.if_pc", if_pc, 32'h0000_0004);
            check_vec("bp.if_pc_plus4", if_pc_plus4, 32'h0000_0008);
            check_vec("bp.if_instr", if_instr, 32'h1300_0004);
            check_vec("bp.req_valid", {31'h0, req_valid}, 32'h0);
            tick();
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;

        fetch_one("seq8", 32'h0000_0008, 32'h1300_0008);

        // Redirect coincident with accept in REQ.
        check_vec("rq_acc.req_addr", req_addr, 32'h0000_000C);
        req_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b0;
        check_vec("rq_acc.req_valid", {31'h0, req_valid}, 32'h0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h1300_000C;
        tick();
        rsp_valid = 1'b0;
        check_vec("rq_acc.if_valid", {31'h0, if_valid}, 32'h0);
        fetch_one("rq_acc_tgt", 32'h0000_2000, 32'h1300_2000);

        // Redirect in REQ without accept.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3001;
        tick();
        redirect_valid = 1'b0;
        fetch_one("rq_stall_tgt", 32'h0000_3000, 32'h1300_3000);

        // Redirect together with the response in WAIT.
        req_ready = 1'b1;
        tick();
        req_ready      = 1'b0;
        rsp_valid      = 1'b1;
        rsp_data       = 32'h1300_3004;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        tick();
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        check_vec("wt_rsp.if_valid", {31'h0, if_valid}, 32'h0);
        fetch_one("wt_rsp_tgt", 32'h0000_4000, 32'h1300_4000);

        // Redirect in HOLD with simultaneous if_ready.
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h1300_4004;
        tick();
        rsp_valid = 1'b0;
        check_vec("hold.if_pc", if_pc, 32'h0000_4004);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        tick();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        check_vec("hold.if_valid", {31'h0, if_valid}, 32'h0);
        fetch_one("hold_tgt", 32'h0000_5000, 32'h1300_5000);

        // Response while in REQ must be ignored.
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD0_0001;
        tick();
        rsp_valid = 1'b0;
        check_vec("stray.if_valid", {31'h0, if_valid}, 32'h0);
        check_vec("stray.req_valid", {31'h0, req_valid}, 32'h1);
        check_vec("stray.req_addr", req_addr, 32'h0000_5004);

        // Reset pulse while waiting for 0x5004.
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_vec("arst.req_valid", {31'h0, req_valid}, 32'h0);
        check_vec("arst.req_addr", req_addr, 32'h0);
        check_vec("arst.if_pc", if_pc, 32'h0);
        check_vec("arst.if_instr", if_instr, 32'h0);
        tick();
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        tick();
        rsp_valid = 1'b0;
        check_vec("arst.late_if_valid", {31'h0, if_valid}, 32'h0);
        fetch_one("arst_seq0", 32'h0000_0000, 32'h1300_0000);
        fetch_one("arst_seq4", 32'h0000_0004, 32'h1300_0004);

        // Redirect to 0x1003 while waiting for 0x8.
        check_vec("wt.req_addr", req_addr, 32'h0000_0008);
        req_ready = 1'b1;
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick();
        redirect_valid = 1'b0;
        check_vec("wt.req_valid", {31'h0, req_valid}, 32'h0);
        rsp_valid = 1'b1;
        rsp_data  = 32'h1300_0008;
        tick();
        rsp_valid = 1'b0;
        check_vec("wt.if_valid", {31'h0, if_valid}, 32'h0);
        fetch_one("wt_tgt", 32'h0000_1000, 32'h1300_1000);

        // Wrap-around instance.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_vec("wrap.req_valid", {31'h0, u1_req_valid}, 32'h1);
        check_vec("wrap.req_addr0", u1_req_addr, 32'hFFFF_FFFC);
        u1_req_ready = 1'b1;
        tick();
        u1_req_ready = 1'b0;
        u1_rsp_valid = 1'b1;
        u1_rsp_data  = 32'h0000_0013;
        tick();
        u1_rsp_valid = 1'b0;
        check_vec("wrap.if_pc", u1_if_pc, 32'hFFFF_FFFC);
        check_vec("wrap.if_pc_plus4", u1_if_pc_plus4, 32'h0000_0000);
        check_vec("wrap.if_instr", u1_if_instr, 32'h0000_0013);
        u1_if_ready = 1'b1;
        tick();
        u1_if_ready = 1'b0;
        check_vec("wrap.req_addr1", u1_req_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
